// File: rtl/uart_debug_host.sv
// uart_debug_host
// Host-side initiator for the CPU debug UART link. Sends one command byte
// ({5'b0, op}) on tx and, for read ops, collects a 4-byte little-endian
// response on rx.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   cmd_valid    command request; accepted when cmd_valid && cmd_ready
//   cmd_ready    high only while idle
//   cmd_op       1=RST_CPU 2=STEP_CPU 3=READ_ADDR 4=READ_RDATA 5=READ_WDATA
//   rsp_valid    one-cycle completion strobe
//   rsp_data     assembled read word (0 for non-read ops), held until next accept
//   rsp_err      timeout, framing error or illegal op; valid with rsp_valid
//   busy         ~cmd_ready
//   tx           serial line to the controller (idle high)
//   rx           serial line from the controller (asynchronous)
module uart_debug_host #(
    parameter int CLKS_PER_BIT = 5002,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        tx,
    input  logic        rx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_BITS - 1);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_STOP,
        RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [31:0]   word_q, word_d;
    logic          err_q, err_d;
    logic          stop_seen_q, stop_seen_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          tx_q, tx_d;
    logic          rx_meta_q, rx_sync_q;
    logic          baud_wrap;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tx        = tx_q;
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        baud_d      = baud_wrap ? '0 : baud_q + BW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        tout_d      = tout_q;
        word_d      = word_q;
        err_d       = err_q;
        stop_seen_d = stop_seen_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        tx_d        = tx_q;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    word_d     = '0;
                    err_d      = 1'b0;
                    if (cmd_op == 3'd0 || cmd_op > 3'd5) begin
                        // Illegal op: nothing goes on the wire.
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = TX_START;
                        tx_d    = 1'b0;
                        shift_d = {5'b0, cmd_op};
                    end
                end
            end

            TX_START: begin
                if (baud_wrap) begin
                    state_d = TX_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = 3'd0;
                end
            end

            TX_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end

            TX_STOP: begin
                if (baud_wrap) begin
                    if (op_q <= 3'd2) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = word_q;
                        rsp_err_d   = err_q;
                    end else begin
                        state_d = RX_WAIT;
                        idx_d   = 2'd0;
                        tout_d  = '0;
                    end
                end
            end

            RX_WAIT: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end else if (baud_wrap) begin
                    if (tout_q == TOUT_LAST) begin
                        // Missing bytes stay zero in word_q.
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = word_q;
                        rsp_err_d   = 1'b1;
                    end else begin
                        tout_d = tout_q + TW'(1);
                    end
                end
            end

            RX_START: begin
                // Half-bit re-check; from here on every sample lands mid-bit.
                if (baud_q == BAUD_HALF) begin
                    baud_d = '0;
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        // Glitch: resume waiting, timeout keeps running.
                        state_d = RX_WAIT;
                    end
                end
            end

            RX_DATA: begin
                if (baud_wrap) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        word_d[{idx_q, 3'b000} +: 8] = {rx_sync_q, shift_q[7:1]};
                        state_d     = RX_STOP;
                        stop_seen_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            RX_STOP: begin
                if (!stop_seen_q) begin
                    if (baud_wrap) begin
                        stop_seen_d = 1'b1;
                        if (!rx_sync_q) begin
                            err_d = 1'b1;
                        end
                    end
                end else if (rx_sync_q) begin
                    // Line back high: byte fully done.
                    if (idx_q == 2'd3) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = word_q;
                        rsp_err_d   = err_q;
                    end else begin
                        state_d = RX_WAIT;
                        idx_d   = idx_q + 2'd1;
                        tout_d  = '0;
                        baud_d  = '0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            tout_q      <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            stop_seen_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            tx_q        <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            tout_q      <= tout_d;
            word_q      <= word_d;
            err_q       <= err_d;
            stop_seen_q <= stop_seen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            tx_q        <= tx_d;
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
        end
    end

endmodule

// File: tb/tb_uart_debug_host.sv
// Directed bench for uart_debug_host with a short bit time. A table of
// commands is replayed through a small UART responder model; the reset and
// mid-frame reset cases are hand-written sequences.
module tb_uart_debug_host;

    localparam int C = 8;
    localparam int TB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        tx;
    logic        rx;

    uart_debug_host #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TB)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int wide_cnt = 0;
    int tx_low = 0;
    int cap_cyc = 0;
    logic [31:0] cap_data = '0;
    logic cap_err = 1'b0;
    bit prev_v = 1'b0;

    always @(posedge clk) cyc++;

    // Response/line monitor at the falling edge.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (prev_v) wide_cnt++;
            rsp_cnt++;
            cap_data = rsp_data;
            cap_err  = rsp_err;
            cap_cyc  = cyc;
        end
        if (!tx) tx_low++;
        prev_v = rsp_valid;
    end

    typedef struct {
        logic [2:0]  op;
        int          nbytes;
        logic [31:0] word;
        int          bad;      // byte index with a 0 stop bit, 4 = none
        bit          glitch;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        repeat (C) tick;
        for (int j = 0; j < 8; j++) begin
            rx = b[j];
            repeat (C) tick;
        end
        rx = good_stop;
        repeat (C) tick;
        rx = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int base_rsp, base_wide, base_low, acc, endc, waited, lat;
        logic [9:0] frm;
        bit legal;
        legal = (v.op >= 3'd1 && v.op <= 3'd5);
        frm = '0;
        tick;
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        base_rsp = rsp_cnt; base_wide = wide_cnt; base_low = tx_low;
        cmd_op = v.op;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        acc = cyc;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("data_cleared", rsp_data, 32'd0);
        if (legal) begin
            repeat (C / 2) tick;
            frm[0] = tx;
            for (int b = 1; b < 10; b++) begin
                repeat (C) tick;
                frm[b] = tx;
            end
            chk("tx_frame", 32'(frm), 32'({1'b1, 5'b0, v.op, 1'b0}));
            chk("no_rsp_during_tx", 32'(rsp_cnt - base_rsp), 32'd0);
            if (v.op >= 3'd3) begin
                repeat (C / 2) tick;
                repeat (3 * C) tick;
                if (v.glitch) begin
                    rx = 1'b0;
                    repeat (2) tick;
                    rx = 1'b1;
                    repeat (C) tick;
                end
                for (int k = 0; k < v.nbytes; k++) begin
                    send_byte(v.word[8*k +: 8], k != v.bad);
                    rx = 1'b1;
                    repeat (C) tick;
                end
            end
        end
        endc = cyc;
        waited = 0;
        while (rsp_cnt == base_rsp && waited < 400) begin
            tick;
            waited++;
        end
        chk("rsp_count", 32'(rsp_cnt - base_rsp), 32'd1);
        tick;
        chk("rsp_single_cycle", 32'(wide_cnt - base_wide), 32'd0);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("rsp_data", cap_data, v.exp_data);
        chk("rsp_err", 32'(cap_err), 32'(v.exp_err));
        lat = cap_cyc - acc;
        if (!legal) begin
            chk("illegal_latency_le2", 32'(lat <= 2), 32'd1);
            chk("illegal_no_tx", 32'(tx_low - base_low), 32'd0);
        end else if (v.op < 3'd3) begin
            chk("op12_latency", 32'(lat >= 10 * C && lat <= 10 * C + 2), 32'd1);
        end else if (v.nbytes < 4) begin
            lat = cap_cyc - endc;
            chk("timeout_latency", 32'(lat >= 110 && lat <= 130), 32'd1);
        end
        repeat (3) tick;
        chk("rsp_data_hold", rsp_data, v.exp_data);
        chk("rsp_err_hold", 32'(rsp_err), 32'(v.exp_err));
    endtask

    initial begin
        int base_rsp, base_low;
        vecs[0] = '{3'd2, 0, 32'h0,          4, 1'b0, 32'h0,          1'b0};
        vecs[1] = '{3'd3, 4, 32'h1234_5678,  4, 1'b0, 32'h1234_5678,  1'b0};
        vecs[2] = '{3'd4, 2, 32'h0000_BEEF,  4, 1'b0, 32'h0000_BEEF,  1'b1};
        vecs[3] = '{3'd5, 4, 32'hCAFE_F00D,  1, 1'b0, 32'hCAFE_F00D,  1'b1};
        vecs[4] = '{3'd3, 4, 32'hA5C3_0F96,  4, 1'b1, 32'hA5C3_0F96,  1'b0};
        vecs[5] = '{3'd6, 0, 32'h0,          4, 1'b0, 32'h0,          1'b1};
        vecs[6] = '{3'd1, 0, 32'h0,          4, 1'b0, 32'h0,          1'b0};
        vecs[7] = '{3'd0, 0, 32'h0,          4, 1'b0, 32'h0,          1'b1};
        vecs[8] = '{3'd7, 0, 32'h0,          4, 1'b0, 32'h0,          1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; rx = 1'b1;
        repeat (3) tick;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of an op 3 command byte.
        tick;
        base_low = tx_low;
        cmd_op = 3'd3;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        repeat (3 * C) tick;
        chk("midreset_busy_before", 32'(busy), 32'd1);
        chk("midreset_tx_active", 32'(tx_low > base_low), 32'd1);
        base_rsp = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_ready", 32'(cmd_ready), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        tick;
        rst_n = 1'b1;
        repeat (15 * C) tick;
        chk("midreset_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
        chk("midreset_idle_after", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
